cordic_arbiter: RTL and testbench

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

---
 rtl/cordic_arb_pkg.sv | 17 +
 rtl/cordic_rr_arbiter.sv | 32 +++
 rtl/cordic_arbiter.sv | 104 ++++++++++
 tb/tb_cordic_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_arb_pkg.sv
// Shared defaults and tag type for the CORDIC request arbiter.
// Optional grant statistics are enabled with CORDIC_ARB_STATS_EN.
package cordic_arb_pkg;

  localparam int NREQ_D  = 4;
  localparam int LAT_D   = 16;
  localparam int W_D     = 16;
  localparam int AW_D    = 32;
  localparam int AN      = 19432;
  localparam int TAG_IDW = 8;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Round-robin one-hot selector, searching upward from ptr.
// Part of the cordic_arbiter slice (CORDIC_ARB_STATS_EN lives in the top).
module cordic_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = IW'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one pipelined CORDIC among NREQ requesters with tagged responses.
// Define CORDIC_ARB_STATS_EN to add per-requester saturating grant counters.
module cordic_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int NREQ = NREQ_D,
  parameter int LAT  = LAT_D,
  parameter int W    = W_D,
  parameter int AW   = AW_D,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_angle,
  output logic [NREQ-1:0]    gnt,
  output logic [W-1:0]       cor_xin,
  output logic [W-1:0]       cor_yin,
  output logic [AW-1:0]      cor_angle,
  input  logic [W-1:0]       cor_cos,
  input  logic [W-1:0]       cor_sin,
  output logic               rsp_valid,
  output logic [IW-1:0]      rsp_id,
  output logic [W-1:0]       rsp_cos,
  output logic [W-1:0]       rsp_sin,
`ifdef CORDIC_ARB_STATS_EN
  input  logic               stat_clr,
  output logic [NREQ*16-1:0] stat_cnt,
`endif
  output logic               busy
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic          any;

  // Stage 0 is loaded with cor_angle; stage LAT lines up with cor_cos/cor_sin.
  tag_t tags [LAT+1];

  assign cor_xin = W'(AN);
  assign cor_yin = '0;

  cordic_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      cor_angle <= '0;
      for (int k = 0; k <= LAT; k++) tags[k] <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_cos   <= '0;
      rsp_sin   <= '0;
    end else begin
      if (any) begin
        cor_angle <= req_angle[idx*AW +: AW];
        ptr       <= (int'(idx) == NREQ-1) ? '0 : idx + 1'b1;
      end
      tags[0] <= '{valid: any, id: TAG_IDW'(idx)};
      for (int k = 1; k <= LAT; k++) tags[k] <= tags[k-1];
      rsp_valid <= tags[LAT].valid;
      if (tags[LAT].valid) begin
        rsp_id  <= tags[LAT].id[IW-1:0];
        rsp_cos <= cor_cos;
        rsp_sin <= cor_sin;
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k <= LAT; k++) busy = busy | tags[k].valid;
  end

`ifdef CORDIC_ARB_STATS_EN
  logic [15:0] cnt [NREQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (stat_clr) cnt[i] <= '0;
        else if (gnt[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NREQ; i++) stat_cnt[i*16 +: 16] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// Self-checking bench: queue-based reference model plus directed scenarios.
// Define CORDIC_ARB_STATS_EN to also exercise the grant counters.
module tb_cordic_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 16;
  localparam int W    = 16;
  localparam int AW   = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   req_angle;
  logic [NREQ-1:0]      gnt;
  logic [W-1:0]         cor_xin, cor_yin;
  logic [AW-1:0]        cor_angle;
  logic [W-1:0]         cor_cos, cor_sin;
  logic                 rsp_valid;
  logic [1:0]           rsp_id;
  logic [W-1:0]         rsp_cos, rsp_sin;
  logic                 busy;
`ifdef CORDIC_ARB_STATS_EN
  logic                 stat_clr;
  logic [NREQ*16-1:0]   stat_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cordic_arbiter #(
    .NREQ (NREQ), .LAT (LAT), .W (W), .AW (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_angle (req_angle),
    .gnt       (gnt),
    .cor_xin   (cor_xin),
    .cor_yin   (cor_yin),
    .cor_angle (cor_angle),
    .cor_cos   (cor_cos),
    .cor_sin   (cor_sin),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_cos   (rsp_cos),
    .rsp_sin   (rsp_sin),
`ifdef CORDIC_ARB_STATS_EN
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt),
`endif
    .busy      (busy)
  );

  // Ideal rotation of (32000, 0): full circle = 2^32 angle units.
  function automatic int ideal(input logic [31:0] a, input bit sine);
    real th, v;
    th = 2.0 * 3.14159265358979 * real'(a) / 4294967296.0;
    v  = 32000.0 * (sine ? $sin(th) : $cos(th));
    return $rtoi($floor(v + 0.5));
  endfunction

  // External CORDIC stand-in: LAT-edge delay from cor_angle to results.
  logic [31:0] cs [1:LAT];
  always @(posedge clk) begin
    cs[1] <= cor_angle;
    for (int k = 2; k <= LAT; k++) cs[k] <= cs[k-1];
  end
  assign cor_cos = W'(ideal(cs[LAT], 1'b0));
  assign cor_sin = W'(ideal(cs[LAT], 1'b1));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d+/-%0d", name, act, exp, tol);
    end
  endtask

  // Reference model: grant search, ordered response queue, held outputs.
  typedef struct {
    int          due;
    int          id;
    logic [31:0] ang;
  } ent_t;

  ent_t        q[$];
  int          cyc = 0;
  int          mptr = 0;
  logic [31:0] m_angle = '0;
  bit          exp_valid = 0;
  int          exp_id = 0, exp_cos = 0, exp_sin = 0;

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  initial forever begin
    int g;
    @(posedge clk or posedge reset);
    cyc++;
    if (reset) begin
      q.delete();
      mptr = 0; m_angle = '0;
      exp_valid = 0; exp_id = 0; exp_cos = 0; exp_sin = 0;
    end else if (clk) begin
      exp_valid = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_valid = 1;
        exp_id  = q[0].id;
        exp_cos = ideal(q[0].ang, 1'b0);
        exp_sin = ideal(q[0].ang, 1'b1);
        void'(q.pop_front());
      end
      g = pick(req, mptr);
      if (g >= 0) begin
        m_angle = req_angle[g*AW +: AW];
        q.push_back('{due: cyc + LAT + 1, id: g, ang: m_angle});
        mptr = (g + 1) % NREQ;
      end
    end
  end

  initial forever begin
    int g;
    logic [NREQ-1:0] eg;
    @(negedge clk);
    if (reset !== 1'b0 && reset !== 1'b1) continue;
    g  = pick(req, mptr);
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("gnt", gnt, eg);
    chk("rsp_valid", rsp_valid, exp_valid);
    chk("busy", busy, q.size() != 0);
    chk("rsp_id", rsp_id, exp_id);
    chk("rsp_cos", $signed(rsp_cos), exp_cos);
    chk("rsp_sin", $signed(rsp_sin), exp_sin);
    chk("cor_angle", cor_angle, m_angle);
    chk("cor_xin", cor_xin, 19432);
    chk("cor_yin", cor_yin, 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string name, output int k);
    bit found;
    found = 0;
    k = 0;
    while (!found && k < 40) begin
      tick();
      k++;
      if (rsp_valid) found = 1;
    end
    chk({name, "_seen"}, found, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  logic [NREQ-1:0] gs [8];
  logic [NREQ-1:0] gexp [8];
  int k, nrsp;

  initial begin
    reset = 1'b1;
    req = '0;
    req_angle = '0;
`ifdef CORDIC_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    #1;
    req = 4'b0110;
    tick(); tick();
    @(negedge clk);
    chk("rst_gnt", gnt, 4'b0010);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cor_angle", cor_angle, 0);
    tick();
    req = '0;
    reset = 1'b0;
    tick();

    // Requester 0 at 0 degrees
    req = 4'b0001;
    tick();
    req = '0;
    wait_rsp("a0", k);
    chk("a0_latency", k, LAT + 1);
    chk("a0_id", rsp_id, 0);
    chk_tol("a0_cos", $signed(rsp_cos), 32000, 5);
    chk_tol("a0_sin", $signed(rsp_sin), 0, 5);
    tick();
    chk("a0_single", rsp_valid, 0);

    // Requester 2 at 30 degrees
    req_angle[2*AW +: AW] = 32'd357913941;
    req = 4'b0100;
    tick();
    req = '0;
    wait_rsp("a30", k);
    chk("a30_latency", k, LAT + 1);
    chk("a30_id", rsp_id, 2);
    chk_tol("a30_cos", $signed(rsp_cos), 27713, 5);
    chk_tol("a30_sin", $signed(rsp_sin), 16000, 5);

    // All four requesting for eight edges
    do_reset();
    for (int i = 0; i < NREQ; i++) req_angle[i*AW +: AW] = 32'(i) * 32'h1000_0000;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      gs[i] = gnt;
      tick();
    end
    req = '0;
    gexp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
             4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 8; i++) chk($sformatf("rr_gnt%0d", i), gs[i], gexp[i]);
    wait_rsp("rr", k);
    chk("rr_id0", rsp_id, 0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("rr_valid%0d", i), rsp_valid, 1);
      chk($sformatf("rr_id%0d", i), rsp_id, i % 4);
    end
    tick();
    chk("rr_done", rsp_valid, 0);

    // Pointer wrap with req=1010
    do_reset();
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      gs[i] = gnt;
      tick();
    end
    req = '0;
    chk("wrap_g0", gs[0], 4'b0010);
    chk("wrap_g1", gs[1], 4'b1000);
    chk("wrap_g2", gs[2], 4'b0010);
    repeat (LAT + 4) tick();

    // Reset while three requests are in flight
    req = 4'b1111;
    repeat (3) tick();
    req = '0;
    repeat (5) tick();
    chk("flush_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("flush_busy", busy, 0);
    chk("flush_rsp_valid", rsp_valid, 0);
    tick(); tick();
    reset = 1'b0;
    nrsp = 0;
    repeat (LAT + 6) begin
      tick();
      if (rsp_valid) nrsp++;
    end
    chk("flush_no_rsp", nrsp, 0);

`ifdef CORDIC_ARB_STATS_EN
    do_reset();
    req = 4'b0010;
    repeat (70000) tick();
    req = '0;
    tick();
    chk("stat1_sat", stat_cnt[31:16], 16'hFFFF);
    chk("stat0_zero", stat_cnt[15:0], 0);
    req = 4'b0010;
    stat_clr = 1'b1;
    tick();
    req = '0;
    stat_clr = 1'b0;
    chk("stat1_clr", stat_cnt[31:16], 0);
    repeat (LAT + 4) tick();
`endif

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
